alu_issue_ctrl: RTL and testbench

Multi-cycle issue/writeback controller that drives the 8-bit ALU as its initiator.
- Accepts register-form instructions over a valid/ready handshake and reads operands from an internal register file.
- Presents A/B/select to the ALU, samples its sum/carry, writes the result back and updates carry/zero status flags.
- Sits between instruction decode and the combinational ALU in the SimpleRISC datapath.

---
 rtl/alu_issue_ctrl_if.sv | 23 ++
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Instruction issue channel between decode and alu_issue_ctrl.
// master = decoder side (offers instructions), slave = issue controller.
interface alu_issue_ctrl_if #(
    parameter int OPW = 4,
    parameter int AW  = 3
);
    logic           instr_valid;
    logic           instr_ready;
    logic [OPW-1:0] instr_op;
    logic [AW-1:0]  instr_rd;
    logic [AW-1:0]  instr_rs1;
    logic [AW-1:0]  instr_rs2;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output instr_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/writeback controller driving a combinational 8-bit ALU.
// Sequence per instruction: accept (IDLE) -> READ operands -> EXEC (ALU
// settles, result captured) -> WB (register file and flags updated).
// Optional debug read port enabled by defining ALU_ISSUE_DBG_EN.
module alu_issue_ctrl #(
    parameter int  WIDTH = 8,
    parameter int  NREGS = 8,
    parameter int  OPW   = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  instr,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_select,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             flag_c,
    output logic             flag_z,
    output logic             busy
`ifdef ALU_ISSUE_DBG_EN
    ,
    input  logic [AW-1:0]    dbg_raddr,
    output logic [WIDTH-1:0] dbg_rdata
`endif
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t           state_q;
    logic [OPW-1:0]   op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OPW-1:0]   sel_q;
    logic [WIDTH-1:0] res_q;
    logic             car_q;
    logic             wb_valid_q;
    logic             flag_c_q;
    logic             flag_z_q;
    logic [WIDTH-1:0] regfile_q [NREGS];

    // r0 is hardwired to zero and addresses beyond NREGS do not exist.
    function automatic logic writable(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREGS);
    endfunction

    function automatic logic [WIDTH-1:0] rf_read(input logic [AW-1:0] a);
        return writable(a) ? regfile_q[a] : '0;
    endfunction

    // Ready only in IDLE; a preload in the same cycle takes priority.
    assign instr.instr_ready = (state_q == IDLE) && !ld_valid && !rst;

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_select = sel_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = rd_q;
    assign wb_data    = res_q;
    assign flag_c     = flag_c_q;
    assign flag_z     = flag_z_q;
    assign busy       = (state_q != IDLE);

`ifdef ALU_ISSUE_DBG_EN
    assign dbg_rdata = rf_read(dbg_raddr);
`endif

    // Issue FSM, operand/result registers, register file and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            sel_q      <= '0;
            res_q      <= '0;
            car_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regfile_q[i] <= '0;
            end
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_valid) begin
                        if (writable(ld_addr)) begin
                            regfile_q[ld_addr] <= ld_data;
                        end
                    end else if (instr.instr_valid) begin
                        op_q    <= instr.instr_op;
                        rd_q    <= instr.instr_rd;
                        rs1_q   <= instr.instr_rs1;
                        rs2_q   <= instr.instr_rs2;
                        state_q <= READ;
                    end
                end
                READ: begin
                    alu_a_q <= rf_read(rs1_q);
                    alu_b_q <= rf_read(rs2_q);
                    sel_q   <= op_q;
                    state_q <= EXEC;
                end
                EXEC: begin
                    // Result is presented on wb_data during the WB cycle.
                    res_q      <= alu_sum;
                    car_q      <= alu_cout;
                    wb_valid_q <= 1'b1;
                    state_q    <= WB;
                end
                WB: begin
                    if (writable(rd_q)) begin
                        regfile_q[rd_q] <= res_q;
                    end
                    flag_c_q <= car_q;
                    flag_z_q <= (res_q == '0);
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural adder ALU and a
// register-file/flag reference model.
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst;
    logic       ld_valid;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_select;
    logic [7:0] alu_sum;
    logic       alu_cout;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       flag_c;
    logic       flag_z;
    logic       busy;
`ifdef ALU_ISSUE_DBG_EN
    logic [2:0] dbg_raddr;
    logic [7:0] dbg_rdata;
`endif

    alu_issue_ctrl_if #(.OPW(4), .AW(3)) instr_if ();

    alu_issue_ctrl #(.WIDTH(8), .NREGS(8), .OPW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr_if),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_sum    (alu_sum),
        .alu_cout   (alu_cout),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .busy       (busy)
`ifdef ALU_ISSUE_DBG_EN
        ,
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
`endif
    );

    // Behavioural ALU: sum = a + b + select[3], carry out in bit 8.
    logic [8:0] alu_full;
    assign alu_full = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_select[3]};
    assign alu_sum  = alu_full[7:0];
    assign alu_cout = alu_full[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_cyc[$];

    // Record the cycle number of every accepted instruction.
    always @(posedge clk) begin
        cyc++;
        if (instr_if.instr_valid && instr_if.instr_ready) acc_cyc.push_back(cyc);
    end

    // Reference state.
    int ref_rf[8];
    int ref_c;
    int ref_z;

    function automatic int rd_model(input int a);
        return (a == 0) ? 0 : ref_rf[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        instr_if.instr_valid = 1'b0;
        ld_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(instr_if.instr_ready), 0);
        end
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        chk("rst_sel", 32'(alu_select), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        chk("rst_flag_c", 32'(flag_c), 0);
        chk("rst_flag_z", 32'(flag_z), 0);
        chk("rst_busy", 32'(busy), 0);
        for (int i = 0; i < 8; i++) ref_rf[i] = 0;
        ref_c = 0;
        ref_z = 0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(instr_if.instr_ready), 1);
    endtask

    task automatic preload(input int a, input int d);
        ld_valid = 1'b1;
        ld_addr  = 3'(a);
        ld_data  = 8'(d);
        #1;
        chk("ld_ready", 32'(instr_if.instr_ready), 0);
        @(negedge clk);
        ld_valid = 1'b0;
        if (a != 0) ref_rf[a] = d & 8'hFF;
    endtask

    // Called at the negedge of the READ cycle; follows the instruction to IDLE.
    task automatic finish_instr(input int op, input int rd, input int rs1, input int rs2);
        int a, b, tot, s, c;
        a   = rd_model(rs1);
        b   = rd_model(rs2);
        tot = a + b + ((op >> 3) & 1);
        s   = tot % 256;
        c   = (tot > 255) ? 1 : 0;
        @(negedge clk);
        ld_valid = 1'b0;
        chk("exec_alu_a", 32'(alu_a), 32'(a));
        chk("exec_alu_b", 32'(alu_b), 32'(b));
        chk("exec_sel", 32'(alu_select), 32'(op));
        chk("exec_busy", 32'(busy), 1);
        chk("exec_wb_valid", 32'(wb_valid), 0);
        @(negedge clk);
        chk("wb_valid", 32'(wb_valid), 1);
        chk("wb_rd", 32'(wb_rd), 32'(rd));
        chk("wb_data", 32'(wb_data), 32'(s));
        chk("wb_old_flag_c", 32'(flag_c), 32'(ref_c));
        @(negedge clk);
        if (rd != 0) ref_rf[rd] = s;
        ref_c = c;
        ref_z = (s == 0) ? 1 : 0;
        chk("idle_wb_valid", 32'(wb_valid), 0);
        chk("flag_c", 32'(flag_c), 32'(ref_c));
        chk("flag_z", 32'(flag_z), 32'(ref_z));
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic run_instr(input int op, input int rd, input int rs1, input int rs2,
                             input bit busy_ld);
        int n0;
        n0 = acc_cyc.size();
        instr_if.instr_valid = 1'b1;
        instr_if.instr_op    = 4'(op);
        instr_if.instr_rd    = 3'(rd);
        instr_if.instr_rs1   = 3'(rs1);
        instr_if.instr_rs2   = 3'(rs2);
        #1;
        chk("issue_ready", 32'(instr_if.instr_ready), 1);
        @(negedge clk);
        instr_if.instr_valid = 1'b0;
        chk("accepted", 32'(acc_cyc.size()), 32'(n0 + 1));
        if (busy_ld) begin
            ld_valid = 1'b1;
            ld_addr  = 3'($urandom_range(1, 7));
            ld_data  = 8'($urandom);
        end
        finish_instr(op, rd, rs1, rs2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b1;
        ld_valid = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        instr_if.instr_valid = 1'b0;
        instr_if.instr_op = '0;
        instr_if.instr_rd = '0;
        instr_if.instr_rs1 = '0;
        instr_if.instr_rs2 = '0;
`ifdef ALU_ISSUE_DBG_EN
        dbg_raddr = '0;
`endif
        do_reset(2);

        // Basic add.
        preload(1, 8'h05);
        preload(2, 8'h03);
        run_instr(4'h0, 3, 1, 2, 1'b0);

        // Carry-in, carry-out and zero result.
        preload(1, 8'hFF);
        preload(2, 8'h01);
        run_instr(4'h8, 4, 1, 2, 1'b0);
        run_instr(4'h0, 5, 1, 2, 1'b0);

        // Back-to-back dependency with instr_valid held high.
        preload(1, 8'h21);
        preload(2, 8'h4C);
        n0 = acc_cyc.size();
        instr_if.instr_valid = 1'b1;
        instr_if.instr_op    = 4'h0;
        instr_if.instr_rd    = 3'd3;
        instr_if.instr_rs1   = 3'd1;
        instr_if.instr_rs2   = 3'd2;
        @(negedge clk);
        instr_if.instr_rd    = 3'd6;
        instr_if.instr_rs1   = 3'd3;
        instr_if.instr_rs2   = 3'd3;
        finish_instr(0, 3, 1, 2);
        @(negedge clk);
        instr_if.instr_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cyc.size()), 32'(n0 + 2));
        if (acc_cyc.size() == n0 + 2)
            chk("b2b_gap", 32'(acc_cyc[n0 + 1] - acc_cyc[n0]), 4);
        finish_instr(0, 6, 3, 3);

        // Load and instruction together: load wins, instruction next cycle.
        n0 = acc_cyc.size();
        ld_valid = 1'b1;
        ld_addr  = 3'd7;
        ld_data  = 8'h42;
        instr_if.instr_valid = 1'b1;
        instr_if.instr_op    = 4'h0;
        instr_if.instr_rd    = 3'd2;
        instr_if.instr_rs1   = 3'd7;
        instr_if.instr_rs2   = 3'd0;
        #1;
        chk("contend_ready", 32'(instr_if.instr_ready), 0);
        @(negedge clk);
        ld_valid = 1'b0;
        ref_rf[7] = 8'h42;
        chk("contend_wait", 32'(acc_cyc.size()), 32'(n0));
        #1;
        chk("contend_ready2", 32'(instr_if.instr_ready), 1);
        @(negedge clk);
        instr_if.instr_valid = 1'b0;
        chk("contend_accept", 32'(acc_cyc.size()), 32'(n0 + 1));
        finish_instr(0, 2, 7, 0);

        // Write to r0 is discarded; r0 still reads zero.
        preload(0, 8'h99);
        run_instr(4'h0, 0, 1, 2, 1'b0);
        run_instr(4'h0, 7, 0, 0, 1'b0);

        // Randomized instructions with preloads and ignored busy-time loads.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) preload($urandom_range(0, 7), $urandom_range(0, 255));
            run_instr($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 2) == 0);
        end

        // Reset during EXEC drops the instruction.
        preload(1, 8'h11);
        preload(2, 8'h22);
        instr_if.instr_valid = 1'b1;
        instr_if.instr_op    = 4'h0;
        instr_if.instr_rd    = 3'd3;
        instr_if.instr_rs1   = 3'd1;
        instr_if.instr_rs2   = 3'd2;
        @(negedge clk);
        instr_if.instr_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        do_reset(1);
        run_instr(4'h0, 4, 1, 2, 1'b0);
        run_instr(4'h8, 5, 3, 7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
